// File: rtl/arm_pkg.sv
// Shared types and constants for the MEM-stage data-memory path.
// Used by sram_controller and its interface.
package arm_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam logic [31:0] DATA_BASE_DEFAULT = 32'd1024;

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        WAIT,
        DONE
    } state_t;

    // Byte address to 32-bit SRAM word index, relative to the data segment base.
    function automatic logic [SRAM_ADDR_W-2:0] word_of(input logic [31:0] addr,
                                                       input logic [31:0] base);
        return (SRAM_ADDR_W-1)'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage load/store handshake between the pipeline (master) and the
// SRAM controller (slave).
interface sram_controller_if;

    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );

endinterface

// File: rtl/sram_controller.sv
// Serves 32-bit MEM-stage loads/stores from a 16-bit async SRAM as two half-word
// accesses. Optional single-entry read cache: define SRAM_CTRL_HIT_BYPASS_EN.
module sram_controller
    import arm_pkg::*;
#(
    parameter logic [31:0] DATA_BASE     = DATA_BASE_DEFAULT,
    parameter int          ACCESS_CYCLES = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_controller_if.slave       mem,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_we_n
);

    localparam logic [4:0] WAIT_LOAD = 5'(ACCESS_CYCLES - 4);

    state_t                 state;
    state_t                 next_state;
    logic                   op_write;
    logic [SRAM_ADDR_W-2:0] word_q;
    logic [31:0]            wdata_q;
    logic [15:0]            rbuf_lo;
    logic [31:0]            read_q;
    logic [4:0]             count;

    logic                   req;
    logic                   ready_c;
    logic                   hit_c;
    logic [31:0]            hit_data;
    logic [SRAM_ADDR_W-2:0] req_word;

    logic [SRAM_ADDR_W-1:0] pin_addr;
    logic [SRAM_DATA_W-1:0] pin_dq;
    logic                   pin_oe;
    logic                   pin_we_n;

    assign req           = mem.rd_en | mem.wr_en;
    assign req_word      = word_of(mem.address, DATA_BASE);
    assign mem.ready     = ready_c;
    assign mem.read_data = read_q;

`ifdef SRAM_CTRL_HIT_BYPASS_EN
    logic                   cache_valid;
    logic [SRAM_ADDR_W-2:0] cache_word;
    logic [31:0]            cache_data;

    assign hit_c    = (state == IDLE) && cache_valid && mem.rd_en && !mem.wr_en
                      && (req_word == cache_word);
    assign hit_data = cache_data;

    // Reads fill the entry; a store to the cached word keeps it coherent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_valid <= 1'b0;
            cache_word  <= '0;
            cache_data  <= '0;
        end else if (state == DONE) begin
            if (!op_write) begin
                cache_valid <= 1'b1;
                cache_word  <= word_q;
                cache_data  <= read_q;
            end else if (cache_valid && cache_word == word_q) begin
                cache_data <= wdata_q;
            end
        end
    end
`else
    assign hit_c    = 1'b0;
    assign hit_data = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ready never depends on the SRAM data bus, only on state and the request.
    always_comb begin
        next_state = state;
        ready_c    = 1'b0;
        case (state)
            IDLE: begin
                ready_c = ~req | hit_c;
                if (req && !hit_c) begin
                    next_state = LOW;
                end
            end
            LOW:  next_state = HIGH;
            HIGH: next_state = WAIT;
            WAIT: begin
                if (count == 5'd0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                ready_c    = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Pin values for the coming cycle, registered so the strobes are glitch-free.
    always_comb begin
        pin_addr = '0;
        pin_dq   = '0;
        pin_oe   = 1'b0;
        pin_we_n = 1'b1;
        if (state == IDLE && next_state == LOW) begin
            pin_addr = {req_word, 1'b0};
            if (mem.wr_en) begin
                pin_dq   = mem.write_data[15:0];
                pin_oe   = 1'b1;
                pin_we_n = 1'b0;
            end
        end else if (state == LOW) begin
            pin_addr = {word_q, 1'b1};
            if (op_write) begin
                pin_dq   = wdata_q[31:16];
                pin_oe   = 1'b1;
                pin_we_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            op_write    <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            rbuf_lo     <= '0;
            read_q      <= '0;
            count       <= '0;
        end else begin
            sram_addr   <= pin_addr;
            sram_dq_out <= pin_dq;
            sram_dq_oe  <= pin_oe;
            sram_we_n   <= pin_we_n;
            if (state == IDLE && next_state == LOW) begin
                op_write <= mem.wr_en;
                word_q   <= req_word;
                wdata_q  <= mem.write_data;
            end
            if (hit_c) begin
                read_q <= hit_data;
            end
            if (state == LOW && !op_write) begin
                rbuf_lo <= sram_dq_in;
            end
            if (state == HIGH) begin
                count <= WAIT_LOAD;
                if (!op_write) begin
                    read_q <= {sram_dq_in, rbuf_lo};
                end
            end
            if (state == WAIT && count != 5'd0) begin
                count <= count - 5'd1;
            end
        end
    end

endmodule
